mmpu_cmd_dispatch: RTL and testbench
====================================

// Module: mmpu_cmd_dispatch
// PURPOSE
//  Parametrised successor to the single-command mMPU command buffer. Queues decoded
//  PIM operations (op, dest/src1/src2 column addresses, row range, crossbar range),
//  then expands each into one mMPU command per row over a valid/ready port, with a
//  per-crossbar enable mask covering a crossbar range. Sits between decode/memory
//  addressing and the crossbar array.
// PARAMETERS
//  ADDR_W     10  width of dest/src1/src2 column addresses
//  ROW_W      10  width of row index (row counter wraps modulo 2^ROW_W)
//  NUM_XBAR   64  number of crossbars; out_xbar_mask width
//  XSEL_W     6   crossbar index width, must satisfy 2^XSEL_W >= NUM_XBAR
//  FIFO_DEPTH 8   command queue entries; power of two, >= 2
// PORTS
//  clk            in   1         rising-edge clock
//  reset_n        in   1         asynchronous, active-low reset
//  flush          in   1         synchronous: drop queue and the active command
//  in_valid       in   1         command offered
//  in_ready       out  1         queue can accept (= !fifo_full)
//  in_op          in   2         00 NOP, 01 READ, 10 WRITE, 11 MAGIC-NOR
//  in_col         in   1         1 = column-mode op: issue once at row_start only
//  in_dest        in   ADDR_W    destination column address
//  in_src1        in   ADDR_W    source-1 column address
//  in_src2        in   ADDR_W    source-2 column address
//  in_row_start   in   ROW_W     first row
//  in_row_end     in   ROW_W     last row (inclusive)
//  in_xbar_start  in   XSEL_W    first enabled crossbar
//  in_xbar_end    in   XSEL_W    last enabled crossbar (inclusive)
//  out_valid      out  1         command presented
//  out_ready      in   1         crossbar side accepts
//  out_op         out  2         op of the current command
//  out_dest/out_src1/out_src2  out  ADDR_W  column addresses of the current command
//  out_row        out  ROW_W     current row
//  out_xbar_mask  out  NUM_XBAR  bit i = crossbar i enabled
//  fifo_empty     out  1         queue holds no entries
//  fifo_full      out  1         queue holds FIFO_DEPTH entries
//  busy           out  1         FSM in ISSUE
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE. All outputs 0 except in_ready=1 and fifo_empty=1.
//  Queue: push on in_valid&&in_ready. in_ready=!fifo_full, with no pass-through when
//   full even if a pop occurs in the same cycle. Push and pop in the same cycle keep
//   the count. Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE and ISSUE.
//   IDLE: if !fifo_empty, pop the head into the working regs and set row=row_start.
//    NOP entry: popped, discarded, stay IDLE. Otherwise go to ISSUE.
//   ISSUE: out_valid=1, outputs held stable until out_ready.
//    On out_valid&&out_ready: if in_col or row==row_end, the command is complete.
//    Otherwise row=row+1 (mod 2^ROW_W) and stay in ISSUE.
//   On completion: if !fifo_empty, pop the next entry in the same edge (back-to-back,
//    no bubble; a NOP head goes to IDLE). Otherwise go to IDLE.
//  Latency: entry accepted at edge t into an empty queue with FSM IDLE -> out_valid
//   high after edge t+1.
//  Row range: row_start>row_end wraps through 2^ROW_W-1 to 0. row_start==row_end
//   gives 1 command. Each expanded command costs exactly 1 cycle when out_ready=1.
//  Mask: bits xbar_start..xbar_end set inclusive. If start>end, wrap: bits start..
//   NUM_XBAR-1 and 0..end. Index >= NUM_XBAR is ignored (that bit is not set).
//   The mask is computed at pop and registered.
//  Flush: has priority over push, pop and issue. Next edge: queue empty, FSM IDLE,
//   out_valid=0. The offered in_valid is not accepted in the flush cycle.
//  Async reset mid-issue: outputs clear immediately. No partial command resumes.
// TESTING
//  1 Reset, push {WRITE,dest=5,src1=1,src2=2,rows 3..6,xbar 0..3}, out_ready=1 ->
//    4 commands rows 3,4,5,6 on consecutive cycles, mask=0xF, first valid at t+1.
//  2 rows 1022..1 (ROW_W=10), xbar 62..1 -> rows 1022,1023,0,1.
//    Mask bits 62,63,0,1 set.
//  3 Push 8 entries with out_ready=0 -> fifo_full=1 and in_ready=0 after the 8th.
//    9th offer is not accepted. Release out_ready -> all 8 commands drain in order,
//    none lost.
//  4 Queue {READ rows 0..1, NOP, MAGIC-NOR col=1 rows 7..9} -> 2 READ commands,
//    NOP produces no command, then exactly 1 MAGIC-NOR command at row 7.
//  5 Toggle out_ready randomly over a 5-row command -> out_* fields stable while
//    valid&&!ready. Each row issued exactly once.
//  6 Assert flush mid-expansion with 3 queued, then deassert reset_n asynchronously
//    mid-issue -> out_valid=0 next edge, fifo_empty=1. On reset, outputs are zero
//    without waiting for a clock edge.

Source files
------------

// File: rtl/mmpu_cmd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : mmpu_cmd_dispatch
//  Purpose  : Queues decoded PIM operations and expands each one into
//             per-row mMPU commands over a valid/ready port, with a
//             registered per-crossbar enable mask for a (possibly wrapping)
//             crossbar range.
//  Revision : 1.0 - initial release
// ============================================================================
module mmpu_cmd_dispatch #(
    parameter int ADDR_W     = 10,
    parameter int ROW_W      = 10,
    parameter int NUM_XBAR   = 64,
    parameter int XSEL_W     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    // command queue input
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic                in_col,
    input  logic [ADDR_W-1:0]   in_dest,
    input  logic [ADDR_W-1:0]   in_src1,
    input  logic [ADDR_W-1:0]   in_src2,
    input  logic [ROW_W-1:0]    in_row_start,
    input  logic [ROW_W-1:0]    in_row_end,
    input  logic [XSEL_W-1:0]   in_xbar_start,
    input  logic [XSEL_W-1:0]   in_xbar_end,
    // expanded command output
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_op,
    output logic [ADDR_W-1:0]   out_dest,
    output logic [ADDR_W-1:0]   out_src1,
    output logic [ADDR_W-1:0]   out_src2,
    output logic [ROW_W-1:0]    out_row,
    output logic [NUM_XBAR-1:0] out_xbar_mask,
    // status
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                busy
);

    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [1:0]       OP_NOP  = 2'b00;
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]        op;
        logic              col;
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ROW_W-1:0]  row_start;
        logic [ROW_W-1:0]  row_end;
        logic [XSEL_W-1:0] xbar_start;
        logic [XSEL_W-1:0] xbar_end;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Queue storage and bookkeeping
    // ------------------------------------------------------------------
    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    entry_t             in_entry;
    entry_t             head;
    logic               push;
    logic               pop;
    logic               last_row;
    logic [NUM_XBAR-1:0] head_mask;

    // ------------------------------------------------------------------
    // Working registers of the command being expanded
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                valid_q;
    logic [1:0]          op_q;
    logic                col_q;
    logic [ADDR_W-1:0]   dest_q;
    logic [ADDR_W-1:0]   src1_q;
    logic [ADDR_W-1:0]   src2_q;
    logic [ROW_W-1:0]    row_q;
    logic [ROW_W-1:0]    row_end_q;
    logic [NUM_XBAR-1:0] mask_q;

    assign in_entry = '{op:         in_op,
                        col:        in_col,
                        dest:       in_dest,
                        src1:       in_src1,
                        src2:       in_src2,
                        row_start:  in_row_start,
                        row_end:    in_row_end,
                        xbar_start: in_xbar_start,
                        xbar_end:   in_xbar_end};

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_MAX);
    assign in_ready   = !fifo_full;

    // A full queue never accepts, even if the head leaves in the same cycle.
    assign push     = in_valid && in_ready && !flush;
    assign last_row = col_q || (row_q == row_end_q);
    // Pop when idle, or when the active command's final row is handed off.
    assign pop      = !flush && !fifo_empty &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_ISSUE) && out_ready && last_row));

    // Crossbar enable mask for the head entry; a start above end wraps through the top index.
    always_comb begin
        int xs;
        int xe;
        head_mask = '0;
        xs        = int'(head.xbar_start);
        xe        = int'(head.xbar_end);
        for (int i = 0; i < NUM_XBAR; i++) begin
            if (xs <= xe) begin
                head_mask[i] = (i >= xs) && (i <= xe);
            end else begin
                head_mask[i] = (i >= xs) || (i <= xe);
            end
        end
    end

    // Queue payload storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Expansion FSM: loads a popped non-NOP entry and steps rows on each handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            op_q      <= '0;
            col_q     <= 1'b0;
            dest_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            row_q     <= '0;
            row_end_q <= '0;
            mask_q    <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else if (pop && (head.op != OP_NOP)) begin
            // Covers both the idle start and the back-to-back hand-off.
            state_q   <= S_ISSUE;
            valid_q   <= 1'b1;
            op_q      <= head.op;
            col_q     <= head.col;
            dest_q    <= head.dest;
            src1_q    <= head.src1;
            src2_q    <= head.src2;
            row_q     <= head.row_start;
            row_end_q <= head.row_end;
            mask_q    <= head_mask;
        end else if ((state_q == S_ISSUE) && out_ready) begin
            if (last_row) begin
                // Completed with nothing (or only a NOP) to follow.
                state_q <= S_IDLE;
                valid_q <= 1'b0;
            end else begin
                row_q <= row_q + ROW_ONE;
            end
        end
    end

    assign busy          = (state_q == S_ISSUE);
    assign out_valid     = valid_q;
    assign out_op        = op_q;
    assign out_dest      = dest_q;
    assign out_src1      = src1_q;
    assign out_src2      = src2_q;
    assign out_row       = row_q;
    assign out_xbar_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_mmpu_cmd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmpu_cmd_dispatch
//  Purpose  : Self-checking bench for mmpu_cmd_dispatch. A queue-based model
//             expands every accepted entry into its expected command stream;
//             a negedge monitor compares each handshake against it and checks
//             hold stability, plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmpu_cmd_dispatch;

    localparam int ADDR_W     = 10;
    localparam int ROW_W      = 10;
    localparam int NUM_XBAR   = 64;
    localparam int XSEL_W     = 6;
    localparam int FIFO_DEPTH = 8;

    logic                clk;
    logic                reset_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic                in_col;
    logic [ADDR_W-1:0]   in_dest;
    logic [ADDR_W-1:0]   in_src1;
    logic [ADDR_W-1:0]   in_src2;
    logic [ROW_W-1:0]    in_row_start;
    logic [ROW_W-1:0]    in_row_end;
    logic [XSEL_W-1:0]   in_xbar_start;
    logic [XSEL_W-1:0]   in_xbar_end;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_op;
    logic [ADDR_W-1:0]   out_dest;
    logic [ADDR_W-1:0]   out_src1;
    logic [ADDR_W-1:0]   out_src2;
    logic [ROW_W-1:0]    out_row;
    logic [NUM_XBAR-1:0] out_xbar_mask;
    logic                fifo_empty;
    logic                fifo_full;
    logic                busy;

    mmpu_cmd_dispatch #(
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .NUM_XBAR(NUM_XBAR),
        .XSEL_W(XSEL_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_col(in_col),
        .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .in_row_start(in_row_start), .in_row_end(in_row_end),
        .in_xbar_start(in_xbar_start), .in_xbar_end(in_xbar_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
        .out_row(out_row), .out_xbar_mask(out_xbar_mask),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        col;
        logic [9:0]  dest, src1, src2, rs, re;
        logic [5:0]  xs, xe;
    } ent_t;

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  dest, src1, src2, row;
        logic [63:0] mask;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    logic [9:0] last_row_seen = '0;
    logic rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one accepted entry into its command stream by walking the ranges.
    function automatic void model_accept(input ent_t e);
        cmd_t c;
        logic [63:0] m;
        int x;
        int r;
        if (e.op == 2'b00) return;
        m = '0;
        x = int'(e.xs);
        for (int guard = 0; guard < 64; guard++) begin
            if (x < NUM_XBAR) m[x] = 1'b1;
            if (x == int'(e.xe)) break;
            x = (x + 1) % 64;
        end
        r = int'(e.rs);
        for (int guard = 0; guard < 1024; guard++) begin
            c.op = e.op; c.dest = e.dest; c.src1 = e.src1; c.src2 = e.src2;
            c.row = r[9:0]; c.mask = m;
            exp_q.push_back(c);
            if (e.col || r == int'(e.re)) break;
            r = (r + 1) % 1024;
        end
    endfunction

    // Single compare process: invariants, hold stability and handshake scoreboard.
    logic        prev_hold = 1'b0;
    cmd_t        prev_c;
    always @(negedge clk) begin
        cmd_t cur;
        cmd_t e;
        ent_t acc;
        if (!reset_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            cur.op = out_op; cur.dest = out_dest; cur.src1 = out_src1;
            cur.src2 = out_src2; cur.row = out_row; cur.mask = out_xbar_mask;
            chk("busy_eq_valid", busy, out_valid);
            chk("in_ready_eq_not_full", in_ready, !fifo_full);
            if (prev_hold && out_valid) begin
                chk("hold_op",   cur.op,   prev_c.op);
                chk("hold_dest", cur.dest, prev_c.dest);
                chk("hold_src1", cur.src1, prev_c.src1);
                chk("hold_src2", cur.src2, prev_c.src2);
                chk("hold_row",  cur.row,  prev_c.row);
                chk("hold_mask", cur.mask, prev_c.mask);
            end
            if (out_valid && out_ready && !flush) begin
                hs_count++;
                last_row_seen = out_row;
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_op",   cur.op,   e.op);
                    chk("cmd_dest", cur.dest, e.dest);
                    chk("cmd_src1", cur.src1, e.src1);
                    chk("cmd_src2", cur.src2, e.src2);
                    chk("cmd_row",  cur.row,  e.row);
                    chk("cmd_mask", cur.mask, e.mask);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                acc.op = in_op; acc.col = in_col; acc.dest = in_dest;
                acc.src1 = in_src1; acc.src2 = in_src2; acc.rs = in_row_start;
                acc.re = in_row_end; acc.xs = in_xbar_start; acc.xe = in_xbar_end;
                model_accept(acc);
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_c    = cur;
        end
    end

    // Random back-pressure during randomized phases.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input ent_t e);
        in_op = e.op; in_col = e.col; in_dest = e.dest; in_src1 = e.src1;
        in_src2 = e.src2; in_row_start = e.rs; in_row_end = e.re;
        in_xbar_start = e.xs; in_xbar_end = e.xe;
    endtask

    // Offer one entry and hold it until the queue takes it (bounded).
    task automatic push_ent(input ent_t e);
        bit done = 1'b0;
        set_ent(e);
        in_valid = 1'b1;
        for (int w = 0; w < 500 && !done; w++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int w = 0; w < 3000 && !done; w++) begin
            if (fifo_empty && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    function automatic ent_t mk(input logic [1:0] op, input logic col,
                                input int dest, input int rs, input int re,
                                input int xs, input int xe);
        ent_t e;
        e.op = op; e.col = col; e.dest = dest[9:0];
        e.src1 = 10'((dest + 1) % 1024); e.src2 = 10'((dest + 2) % 1024);
        e.rs = rs[9:0]; e.re = re[9:0]; e.xs = xs[5:0]; e.xe = xe[5:0];
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e;
        int   hs0;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_ent(mk(2'b00, 1'b0, 0, 0, 0, 0, 0));
        #2;
        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mask", out_xbar_mask, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Test 1: WRITE rows 3..6, xbar 0..3, first valid one edge after acceptance
        out_ready = 1'b1;
        e = mk(2'b10, 1'b0, 5, 3, 6, 0, 3);
        e.src1 = 10'd1; e.src2 = 10'd2;
        push_ent(e);
        chk("t1_latency_not_yet", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_row3", out_row, 3);
        chk("t1_mask", out_xbar_mask, 64'hF);
        chk("t1_op", out_op, 2'b10);
        chk("t1_dest", out_dest, 5);
        tick(); chk("t1_row4", out_row, 4);
        tick(); chk("t1_row5", out_row, 5);
        tick(); chk("t1_row6", out_row, 6); chk("t1_valid6", out_valid, 1);
        tick(); chk("t1_done", out_valid, 0);

        // Test 2: row and crossbar wrap
        push_ent(mk(2'b01, 1'b0, 20, 1022, 1, 62, 1));
        tick();
        chk("t2_row1022", out_row, 1022);
        chk("t2_mask", out_xbar_mask, 64'hC000_0000_0000_0003);
        tick(); chk("t2_row1023", out_row, 1023);
        tick(); chk("t2_row0", out_row, 0);
        tick(); chk("t2_row1", out_row, 1);
        tick(); chk("t2_done", out_valid, 0);

        // Test 3: fill the queue behind an issuing command, then drain
        out_ready = 1'b0;
        hs0 = hs_count;
        push_ent(mk(2'b10, 1'b0, 100, 100, 100, 5, 5));
        tick();
        chk("t3_blocker_issuing", busy, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) push_ent(mk(2'b11, 1'b0, 10 + i, i, i, i, i + 1));
        chk("t3_full", fifo_full, 1);
        chk("t3_in_ready", in_ready, 0);
        set_ent(mk(2'b01, 1'b0, 999, 0, 0, 0, 0));
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_ninth_refused", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("t3_count", hs_count - hs0, FIFO_DEPTH + 1);
        chk("t3_model_empty", exp_q.size(), 0);

        // Test 4: READ, NOP, column-mode MAGIC-NOR
        hs0 = hs_count;
        push_ent(mk(2'b01, 1'b0, 30, 0, 1, 0, 0));
        push_ent(mk(2'b00, 1'b0, 31, 0, 3, 0, 0));
        push_ent(mk(2'b11, 1'b1, 32, 7, 9, 2, 4));
        drain();
        chk("t4_count", hs_count - hs0, 3);
        chk("t4_last_row", last_row_seen, 7);

        // Test 5: random back-pressure across a 5-row command
        hs0 = hs_count;
        out_ready = 1'b0;
        push_ent(mk(2'b10, 1'b0, 40, 50, 54, 10, 20));
        rand_ready = 1'b1;
        drain();
        rand_ready = 1'b0;
        tick();
        chk("t5_count", hs_count - hs0, 5);

        // Randomized traffic with back-pressure and occasional flush
        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int rs;
            rs = $urandom_range(0, 1023);
            e = mk(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                   $urandom_range(0, 1023), rs, (rs + $urandom_range(0, 3)) % 1024,
                   $urandom_range(0, 63), $urandom_range(0, 63));
            push_ent(e);
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1; tick(); flush = 1'b0;
            end
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();
        chk("rand_model_empty", exp_q.size(), 0);

        // Test 6: flush mid-expansion with 3 queued, in_valid offered during flush
        out_ready = 1'b0;
        push_ent(mk(2'b10, 1'b0, 60, 0, 20, 0, 7));
        tick();
        for (int i = 0; i < 3; i++) push_ent(mk(2'b01, 1'b0, 61 + i, i, i + 2, 0, 0));
        chk("t6_queued", fifo_empty, 0);
        set_ent(mk(2'b01, 1'b0, 70, 0, 0, 0, 0));
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_empty", fifo_empty, 1);
        chk("t6_flush_busy", busy, 0);
        tick();
        chk("t6_flush_no_accept", fifo_empty, 1);
        chk("t6_flush_idle", out_valid, 0);

        // Asynchronous reset mid-issue
        push_ent(mk(2'b11, 1'b0, 80, 0, 5, 3, 9));
        tick();
        chk("t6_issuing", out_valid, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_row", out_row, 0);
        chk("t6_async_mask", out_xbar_mask, 0);
        chk("t6_async_empty", fifo_empty, 1);
        chk("t6_async_in_ready", in_ready, 1);
        tick(); tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        chk("t6_no_resume", out_valid, 0);
        chk("t6_model_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
